// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
// Holds the opcode/funct encodings, the forwarding-source enum and the captured control struct.
package id_ex_stage_pkg;

    localparam logic [6:0] RTYPEOP   = 7'b0110011;
    localparam logic [6:0] ITYPEOP   = 7'b0010011;
    localparam logic [2:0] SRLFUNCT3 = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       reg_write;
        logic       mem_read;
    } id_ex_t;

    // Shift-immediates carry their arithmetic/logical selector in imm[11:5].
    function automatic logic [6:0] capture_funct7(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7,
        input logic [6:0] imm_hi
    );
        logic [6:0] result;
        result = 7'b0;
        if (opcode == RTYPEOP) begin
            result = funct7;
        end else if (opcode == ITYPEOP && funct3 == SRLFUNCT3) begin
            result = imm_hi;
        end
        return result;
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB beats the stored register value.
// x0 is never forwarded, so a write to x0 upstream cannot corrupt a zero operand.
module operand_forward
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic [REGADDR-1:0] rs_addr,
    input  logic [WIDTH-1:0]   reg_data,
    input  logic [REGADDR-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic [WIDTH-1:0]   exmem_result,
    input  logic [REGADDR-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    input  logic [WIDTH-1:0]   memwb_result,
    output logic [WIDTH-1:0]   fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (exmem_reg_write && exmem_rd == rs_addr && rs_addr != '0) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && memwb_rd == rs_addr && rs_addr != '0) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_result;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU: captures decoded instructions,
// inserts load-use bubbles, refreshes held operands from MEM/WB and forwards operands.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [REGADDR-1:0] id_rs1_addr,
    input  logic [REGADDR-1:0] id_rs2_addr,
    input  logic [REGADDR-1:0] id_rd_addr,
    input  logic [WIDTH-1:0]   id_rs1_data,
    input  logic [WIDTH-1:0]   id_rs2_data,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [6:0]         id_opcode,
    input  logic [2:0]         id_funct3,
    input  logic [6:0]         id_funct7,
    input  logic               id_mem_read,
    input  logic               id_reg_write,
    input  logic [REGADDR-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic [WIDTH-1:0]   exmem_result,
    input  logic [REGADDR-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    input  logic [WIDTH-1:0]   memwb_result,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [WIDTH-1:0]   ex_op1,
    output logic [WIDTH-1:0]   ex_op2,
    output logic [6:0]         ex_opcode,
    output logic [2:0]         ex_funct3,
    output logic [6:0]         ex_funct7,
    output logic [REGADDR-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic [WIDTH-1:0]   ex_rs2_fwd
);

    logic               valid_reg;
    id_ex_t             ctrl_reg;
    id_ex_t             ctrl_next;
    logic [REGADDR-1:0] rs1_addr_reg;
    logic [REGADDR-1:0] rs2_addr_reg;
    logic [REGADDR-1:0] rd_reg;
    logic [WIDTH-1:0]   rs1_data_reg;
    logic [WIDTH-1:0]   rs2_data_reg;
    logic [WIDTH-1:0]   imm_reg;

    logic               adv;
    logic               haz;
    logic               refresh_rs1;
    logic               refresh_rs2;
    logic [WIDTH-1:0]   fwd_rs1;
    logic [WIDTH-1:0]   fwd_rs2;

    assign adv = ~valid_reg | ex_ready;

    // Load in EX whose destination is needed by the instruction in decode.
    assign haz = valid_reg & ctrl_reg.mem_read & (rd_reg != '0) &
                 ((rd_reg == id_rs1_addr) |
                  ((rd_reg == id_rs2_addr) & (id_opcode == RTYPEOP)));

    assign id_ready = ~rst & adv & ~haz & ~flush;

    assign refresh_rs1 = memwb_reg_write & (memwb_rd == rs1_addr_reg) & (rs1_addr_reg != '0);
    assign refresh_rs2 = memwb_reg_write & (memwb_rd == rs2_addr_reg) & (rs2_addr_reg != '0);

    always_comb begin
        ctrl_next           = '0;
        ctrl_next.opcode    = id_opcode;
        ctrl_next.funct3    = id_funct3;
        ctrl_next.funct7    = capture_funct7(id_opcode, id_funct3, id_funct7, id_imm[11:5]);
        ctrl_next.reg_write = id_reg_write;
        ctrl_next.mem_read  = id_mem_read;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            ctrl_reg     <= '0;
            rs1_addr_reg <= '0;
            rs2_addr_reg <= '0;
            rd_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
        end else if (flush || (adv && haz)) begin
            valid_reg          <= 1'b0;
            ctrl_reg.reg_write <= 1'b0;
            ctrl_reg.mem_read  <= 1'b0;
        end else if (adv) begin
            valid_reg <= id_valid;
            if (id_valid) begin
                ctrl_reg     <= ctrl_next;
                rs1_addr_reg <= id_rs1_addr;
                rs2_addr_reg <= id_rs2_addr;
                rd_reg       <= id_rd_addr;
                rs1_data_reg <= id_rs1_data;
                rs2_data_reg <= id_rs2_data;
                imm_reg      <= id_imm;
            end
        end else begin
            // Stalled: absorb values retiring now so they survive past the MEM/WB window.
            if (refresh_rs1) begin
                rs1_data_reg <= memwb_result;
            end
            if (refresh_rs2) begin
                rs2_data_reg <= memwb_result;
            end
        end
    end

    operand_forward #(
        .WIDTH   (WIDTH),
        .REGADDR (REGADDR)
    ) u_fwd_rs1 (
        .rs_addr         (rs1_addr_reg),
        .reg_data        (rs1_data_reg),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs1)
    );

    operand_forward #(
        .WIDTH   (WIDTH),
        .REGADDR (REGADDR)
    ) u_fwd_rs2 (
        .rs_addr         (rs2_addr_reg),
        .reg_data        (rs2_data_reg),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs2)
    );

    assign ex_valid     = valid_reg;
    assign ex_op1       = fwd_rs1;
    assign ex_op2       = (ctrl_reg.opcode == RTYPEOP) ? fwd_rs2 : imm_reg;
    assign ex_rs2_fwd   = fwd_rs2;
    assign ex_opcode    = ctrl_reg.opcode;
    assign ex_funct3    = ctrl_reg.funct3;
    assign ex_funct7    = ctrl_reg.funct7;
    assign ex_rd        = rd_reg;
    assign ex_reg_write = valid_reg & ctrl_reg.reg_write;
    assign ex_mem_read  = valid_reg & ctrl_reg.mem_read;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the execute ALU. Captures one decoded instruction per handshake and presents registered control fields to the ALU.
- Presents op1/op2 after register-vs-immediate selection and EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts a one-cycle bubble.
- Keeps held operands current while downstream stalls.

Parameters:
- WIDTH, 32, datapath width.
- REGADDR, 5, register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard the held instruction (branch redirect)
- id_valid  in  1  decode offers an instruction
- id_ready  out  1  stage accepts this cycle
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REGADDR each  register indices
- id_rs1_data, id_rs2_data  in  WIDTH each  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_opcode  in  7  instruction opcode
- id_funct3  in  3  function code
- id_funct7  in  7  function code
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes rd
- exmem_rd  in  REGADDR  EX/MEM forwarding source register
- exmem_reg_write  in  1  EX/MEM forwarding source writes rd
- exmem_result  in  WIDTH  EX/MEM forwarding source value
- memwb_rd  in  REGADDR  MEM/WB forwarding source register
- memwb_reg_write  in  1  MEM/WB forwarding source writes rd
- memwb_result  in  WIDTH  MEM/WB forwarding source value
- ex_valid  out  1  ALU inputs hold a real instruction
- ex_ready  in  1  downstream consumes this cycle
- ex_op1, ex_op2  out  WIDTH each  ALU operands
- ex_opcode  out  7  to ALU
- ex_funct3  out  3  to ALU
- ex_funct7  out  7  to ALU
- ex_rd  out  REGADDR  forwarded to the next stage
- ex_reg_write  out  1  forwarded to the next stage
- ex_mem_read  out  1  forwarded to the next stage
- ex_rs2_fwd  out  WIDTH  forwarded rs2 for store data

Behaviour:
- Reset (async, rst=1): every registered field and every output is 0; ex_valid=0. Reset mid-stall drops the held instruction.
- Advance condition: adv = ~ex_valid | ex_ready.
- Hazard condition: haz = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1_addr | (ex_rd==id_rs2_addr & id_opcode==RTYPEOP)).
- Handshake: id_ready = adv & ~haz & ~flush.
- Clock edge, in priority order:
  - flush: ex_valid<=0.
  - else if adv & haz: bubble, ex_valid<=0, reg_write/mem_read cleared.
  - else if adv: ex_valid<=id_valid; when id_valid, capture all id_* fields.
  - else: hold the instruction and apply refresh.
- No combinational path from ex_ready to the captured registers other than through adv.
- Refresh while holding: per rs, if memwb_reg_write & memwb_rd==rs & rs!=0, the stored rs data <= memwb_result. A value retiring during a stall is never lost.
- Forwarding (combinational on the outputs, per rs):
  - EX/MEM match (reg_write, rd==rs, rs!=0) wins.
  - else MEM/WB match.
  - else stored data.
  - x0 is never forwarded.
- Operand select:
  - ex_op1 = fwd_rs1.
  - ex_op2 = fwd_rs2 for RTYPEOP, id_imm (stored) for every other opcode.
  - ex_rs2_fwd = fwd_rs2 always.
- Captured ex_funct7:
  - id_funct7 for RTYPEOP.
  - id_imm[11:5] for ITYPEOP with SRLFUNCT3, so SRAI/SRLI reach the ALU correctly.
  - 7'b0 otherwise.
- When ex_valid=0, ex_op1/ex_op2 may be any value, but ex_reg_write and ex_mem_read must be 0.
- Latency: 1 cycle from accept to ex_valid. Throughput: 1 per cycle when ex_ready=1 and no hazard.
- Simultaneous flush with id_valid: the instruction is not accepted (id_ready=0).
- Simultaneous hazard with ex_ready=0: hold; no bubble until adv.

Decomposition:
- Opcode and funct constants (RTYPEOP, ITYPEOP, SRLFUNCT3, …) come from the shared opcode constants include; no local redefinitions.
- Add to the shared package:
  - fwd_sel_e enum {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
  - id_ex_t packed struct of the captured fields.
- One sub-module, operand_forward: pure combinational per-operand priority mux, instantiated twice (rs1, rs2).

Test Plan:
- Reset held with id_valid=1: all outputs 0, ex_valid=0. Release rst, ADD x3,x1,x2 with rs1=5, rs2=7 → next cycle ex_op1=5, ex_op2=7, ex_funct7=0.
- SRAI x4,x1,3 with imm=0x403, funct3=SRLFUNCT3, rs1_data=0x80000000 → ex_op2=0x403, ex_funct7=7'b0100000.
- Back-to-back ADD x5 then SUB x6,x5,x2 with exmem_rd=5, exmem_result=0x11, and memwb_rd=5 with value 0x22 → ex_op1=0x11 (EX/MEM priority). With rd=0 in both sources → stored data used.
- LW x7 in EX (ex_mem_read=1) while decode offers ADD x8,x7,x1 → id_ready=0 for one cycle, then one bubble (ex_valid=0), then ADD accepted.
- ex_ready=0 for 3 cycles holding ADD x9,x2,x3; memwb_rd=2 with value 0xAB pulses in cycle 2 → after release ex_op1=0xAB with no forwarding active.
- flush asserted with the stage full and id_valid=1 → next cycle ex_valid=0, ex_reg_write=0, id_ready=0 during the flush cycle.
